uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter among NUM_REQ byte sources using round-robin arbitration.
- Generates the transmitter's baud tick and drives its start and data inputs.
- Holds the data byte stable for the whole frame and releases the next grant only after the transmitter signals done.
- Sits between client logic (command/status sources) and the UART transmitter. Its outputs connect directly to the transmitter's tx_start/tx_baud/data_in, and tx_done returns from it.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CLK_DIV, 434, clock cycles per baud tick (>=1; 434 = 50 MHz / 115200).
- ID_W, $clog2(NUM_REQ), width of grant_id.
- DIV_W, $clog2(CLK_DIV+1), baud counter width.

Ports:
- clock, input, 1, system clock; all logic on posedge.
- reset, input, 1, asynchronous, active-high reset.
- enable, input, 1, 1 = new grants allowed; 0 = finish the current frame, then hold.
- req_valid, input, NUM_REQ, per-requester byte-available flag.
- req_data, input, 8*NUM_REQ, byte i is bits [8i+7:8i].
- req_ready, output, NUM_REQ, one-cycle pulse when byte i has been latched.
- tx_baud, output, 1, one-cycle baud tick to the transmitter.
- tx_start, output, 1, frame start request to the transmitter.
- data_out, output, 8, byte to the transmitter; stable from grant until done.
- tx_done, input, 1, transmitter end-of-frame pulse.
- busy, output, 1, high in any state other than IDLE.
- grant_id, output, ID_W, index of the requester owning the current frame.

Behaviour:
- Reset (async, reset=1) forces:
  - state=IDLE; baud counter=0; rr pointer=0.
  - tx_baud=0, tx_start=0, data_out=8'h00, req_ready=0, busy=0, grant_id=0.
- Baud generator:
  - Free-running counter 0..CLK_DIV-1.
  - tx_baud is registered and high exactly one cycle when the counter wraps, i.e. period CLK_DIV cycles. The first tick occurs CLK_DIV cycles after reset release.
  - CLK_DIV=1 gives tx_baud continuously high after the first cycle.
- FSM states: IDLE, START, BUSY.
- IDLE:
  - Transition condition: enable=1 and any req_valid.
  - Winner = first set bit scanning from rr pointer upward, wrapping modulo NUM_REQ.
  - On that edge, registered updates:
    - data_out <= req_data[winner]; grant_id <= winner.
    - req_ready[winner] pulses one cycle.
    - rr pointer <= (winner+1) mod NUM_REQ.
    - state <= START.
  - Otherwise the FSM stays in IDLE.
- START:
  - tx_start=1 (decoded from the state).
  - When tx_baud=1 in this state, the transmitter accepts, and state <= BUSY on the same edge.
- BUSY:
  - tx_start=0; wait for tx_done=1, then state <= IDLE.
  - A new grant is possible on the cycle after returning to IDLE.
- Latency: req_valid high in IDLE → req_ready pulse and data_out updated 1 cycle later; tx_start high from that cycle until the next tx_baud.
- Handshake rules:
  - Requesters hold req_valid and req_data until req_ready.
  - Dropping req_valid before grant loses the request without error.
  - req_ready is never high for more than one bit or one cycle at a time.
- data_out and grant_id change only on a grant. They hold their value through BUSY and IDLE.
- tx_done in IDLE or START: ignored (no state change).
- enable deasserted in START or BUSY: the current frame completes normally; no new grant follows.
- Single requester with continuous valid: granted every frame; the rr pointer still advances.
- Simultaneous requests, pointer at p: lowest index >= p wins, else lowest index overall.
- reset mid-frame:
  - Immediate return to reset values; tx_start drops asynchronously.
  - The latched byte is lost, and the requester has already seen req_ready.
  - The transmitter is reset by the same system reset.

Decomposition:
- Shared package uart_pkg:
  - FSM state enum (ARB_IDLE, ARB_START, ARB_BUSY).
  - Constant DEFAULT_CLK_DIV=434 and byte width 8.
- One sub-module is natural: uart_baud_gen (CLK_DIV parameter; ports clock, reset, tick).
- The round-robin pick stays inline as a combinational function.

Test Plan:
- Reset then idle, CLK_DIV=4 → tx_baud pulses on cycles 4, 8, 12, ...; all other outputs at reset values; busy=0.
- Only req_valid[2]=1, data 8'hA5 → next cycle req_ready=4'b0100, data_out=8'hA5, grant_id=2, tx_start=1 until first tx_baud. Then busy until a tx_done pulse, then IDLE.
- req_valid=4'b1111 held continuously, bytes 11/22/33/44 → grant order 0,1,2,3,0 with matching data_out. Exactly one req_ready pulse per frame.
- Pointer=2, req_valid=4'b0011 → grant 0, then 1.
- enable=0 during BUSY with requests pending → current frame ends on tx_done; no further tx_start or req_ready until enable=1.
- Assert reset during BUSY → tx_start=0, busy=0, data_out=0 immediately. After release, a pending req_valid is re-arbitrated from pointer 0.
- tx_done pulse injected in START → remains START; proceeds to BUSY on the next tx_baud.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and FSM encodings for the UART transmit arbiter.
package uart_pkg;

  localparam int unsigned DEFAULT_CLK_DIV = 434;
  localparam int unsigned BYTE_W          = 8;

  // Arbiter FSM encodings
  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_START = 2'd1;
  localparam logic [1:0] ARB_BUSY  = 2'd2;

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running baud tick generator: one-cycle registered tick every CLK_DIV cycles.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV,
  parameter int unsigned DIV_W   = $clog2(CLK_DIV + 1)
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Count 0..CLK_DIV-1 and raise the tick on the cycle after the wrap
  always_comb begin
    cnt_d  = cnt_q + DIV_W'(1);
    tick_d = 1'b0;
    if (cnt_q == DIV_W'(CLK_DIV - 1)) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end
  end

  // Counter and tick registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV,
  parameter int unsigned ID_W    = $clog2(NUM_REQ),
  parameter int unsigned DIV_W   = $clog2(CLK_DIV + 1)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_baud,
  output logic                      tx_start,
  output logic [BYTE_W-1:0]         data_out,
  input  logic                      tx_done,
  output logic                      busy,
  output logic [ID_W-1:0]           grant_id
);

  logic [1:0]         state_q, state_d;
  logic [ID_W-1:0]    rr_q, rr_d;
  logic [ID_W-1:0]    grant_q, grant_d;
  logic [BYTE_W-1:0]  data_q, data_d;
  logic [NUM_REQ-1:0] ready_q, ready_d;
  logic [ID_W-1:0]    win;
  logic [BYTE_W-1:0]  win_data;

  // First set bit at or above ptr, wrapping modulo NUM_REQ
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                              input logic [ID_W-1:0]    ptr);
    logic [ID_W-1:0] pick;
    logic [ID_W-1:0] cand;
    logic            found;
    pick  = '0;
    found = 1'b0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = ID_W'((32'(ptr) + off) % NUM_REQ);
      if (!found && valid[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  uart_baud_gen #(
    .CLK_DIV (CLK_DIV),
    .DIV_W   (DIV_W)
  ) u_baud_gen (
    .clock (clock),
    .reset (reset),
    .tick  (tx_baud)
  );

  assign win = rr_pick(req_valid, rr_q);

  // Byte mux for the winning requester, constant slices only
  always_comb begin
    win_data = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (ID_W'(i) == win) win_data = req_data[i*BYTE_W +: BYTE_W];
    end
  end

  // Arbitration FSM next-state and grant bookkeeping
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    data_d  = data_q;
    ready_d = '0;
    case (state_q)
      ARB_IDLE: begin
        if (enable && (|req_valid)) begin
          data_d       = win_data;
          grant_d      = win;
          ready_d[win] = 1'b1;
          rr_d         = ID_W'((32'(win) + 32'd1) % NUM_REQ);
          state_d      = ARB_START;
        end
      end
      // The transmitter samples tx_start on the baud tick
      ARB_START: if (tx_baud) state_d = ARB_BUSY;
      ARB_BUSY:  if (tx_done) state_d = ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase
  end

  // State and grant registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      rr_q    <= '0;
      grant_q <= '0;
      data_q  <= '0;
      ready_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      ready_q <= ready_d;
    end
  end

  assign tx_start  = (state_q == ARB_START);
  assign busy      = (state_q != ARB_IDLE);
  assign data_out  = data_q;
  assign grant_id  = grant_q;
  assign req_ready = ready_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with NUM_REQ=4, CLK_DIV=4.
module tb_uart_tx_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic        tx_baud;
  logic        tx_start;
  logic [7:0]  data_out;
  logic        tx_done = 1'b0;
  logic        busy;
  logic [1:0]  grant_id;

  int n_vec = 0;
  int n_err = 0;
  int n_pop = 0;

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
  } grant_t;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [1:0]  exp_id;
    logic [7:0]  exp_data;
  } vec_t;

  grant_t sb_q[$];
  vec_t   vecs[10];

  uart_tx_arbiter #(
    .NUM_REQ (4),
    .CLK_DIV (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx_baud   (tx_baud),
    .tx_start  (tx_start),
    .data_out  (data_out),
    .tx_done   (tx_done),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out waiting, expected event within 32 cycles", name);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [1:0] id, input logic [7:0] data);
    grant_t g;
    g.id   = id;
    g.data = data;
    sb_q.push_back(g);
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (req_ready == 4'b0000 && n < 32) begin
      step();
      n++;
    end
    if (n >= 32) timeout(name);
  endtask

  task automatic wait_baud(input string name);
    int n = 0;
    while (tx_baud !== 1'b1 && n < 32) begin
      step();
      n++;
    end
    if (n >= 32) timeout(name);
  endtask

  task automatic wait_busy(input string name);
    int n = 0;
    while (!(busy === 1'b1 && tx_start === 1'b0) && n < 32) begin
      step();
      n++;
    end
    if (n >= 32) timeout(name);
  endtask

  task automatic done_pulse();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    tx_done   = 1'b0;
    enable    = 1'b0;
    step();
    step();
    check("rst_outputs", {tx_baud, tx_start, busy, req_ready, grant_id, data_out},
          32'h0);
    reset = 1'b0;
  endtask

  // Scoreboard: every req_ready pulse must match the oldest expected grant
  always @(negedge clock) begin
    if (!reset && req_ready != 4'b0000) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_unexpected: got ready %b id %0d, expected no grant", req_ready,
                 grant_id);
      end else begin
        grant_t g;
        g = sb_q.pop_front();
        n_pop++;
        check("sb_ready", req_ready, 4'b0001 << g.id);
        check("sb_id", grant_id, g.id);
        check("sb_data", data_out, g.data);
      end
    end
  end

  initial begin
    int   pops0;
    logic held;

    vecs[0] = '{4'b0100, 32'h00A5_0000, 2'd2, 8'hA5};
    vecs[1] = '{4'b0011, 32'h0000_BB3C, 2'd0, 8'h3C};
    vecs[2] = '{4'b0011, 32'h0000_5AC3, 2'd1, 8'h5A};
    vecs[3] = '{4'b1001, 32'h7E00_0081, 2'd3, 8'h7E};
    vecs[4] = '{4'b1001, 32'hF000_000F, 2'd0, 8'h0F};
    vecs[5] = '{4'b0010, 32'h0000_2200, 2'd1, 8'h22};
    vecs[6] = '{4'b0011, 32'h0000_EE77, 2'd0, 8'h77};
    vecs[7] = '{4'b0011, 32'h0000_EE77, 2'd1, 8'hEE};
    vecs[8] = '{4'b1111, 32'h4433_2211, 2'd2, 8'h33};
    vecs[9] = '{4'b1000, 32'hFF00_0000, 2'd3, 8'hFF};

    // Reset and idle: baud ticks on cycles 4, 8, 12 only
    do_reset();
    for (int c = 1; c <= 12; c++) begin
      step();
      check($sformatf("baud_c%0d", c), tx_baud, (c % 4 == 0) ? 1 : 0);
    end
    check("idle_outputs", {tx_start, busy, req_ready, grant_id, data_out}, 32'h0);

    // Continuous requests from all four: order 0,1,2,3,0
    pops0     = n_pop;
    enable    = 1'b1;
    req_data  = 32'h4433_2211;
    req_valid = 4'b1111;
    push(2'd0, 8'h11);
    push(2'd1, 8'h22);
    push(2'd2, 8'h33);
    push(2'd3, 8'h44);
    push(2'd0, 8'h11);
    for (int f = 0; f < 5; f++) begin
      wait_ready("rr_ready");
      if (f == 4) req_valid = '0;
      wait_busy("rr_busy");
      done_pulse();
    end
    step();
    check("rr_pulses", n_pop - pops0, 5);
    check("rr_sb_empty", sb_q.size(), 0);

    // Table-driven single grants, pointer restarts from 0
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      req_valid = vecs[i].valid;
      req_data  = vecs[i].data;
      push(vecs[i].exp_id, vecs[i].exp_data);
      step();
      check($sformatf("v%0d_ready", i), req_ready, 4'b0001 << vecs[i].exp_id);
      check($sformatf("v%0d_id", i), grant_id, vecs[i].exp_id);
      check($sformatf("v%0d_data", i), data_out, vecs[i].exp_data);
      check($sformatf("v%0d_start", i), {busy, tx_start}, 2'b11);
      req_valid = '0;
      wait_baud($sformatf("v%0d_baud", i));
      step();
      check($sformatf("v%0d_busy", i), {busy, tx_start}, 2'b10);
      done_pulse();
      check($sformatf("v%0d_idle", i), {busy, tx_start, req_ready}, 0);
      check($sformatf("v%0d_hold", i), {grant_id, data_out},
            {vecs[i].exp_id, vecs[i].exp_data});
    end

    // enable dropped during BUSY: frame completes, no new grant until re-enabled
    req_valid = 4'b0001;
    req_data  = 32'h0000_00C1;
    push(2'd0, 8'hC1);
    wait_ready("en_ready");
    wait_busy("en_busy");
    enable = 1'b0;
    done_pulse();
    check("en_idle", busy, 0);
    held = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (tx_start !== 1'b0 || req_ready !== 4'b0000 || busy !== 1'b0) held = 1'b1;
    end
    check("en_hold_quiet", held, 0);
    enable = 1'b1;
    push(2'd0, 8'hC1);
    wait_ready("en_ready2");
    req_valid = '0;
    wait_busy("en_busy2");
    done_pulse();

    // tx_done injected in START is ignored
    wait_baud("ds_align");
    req_valid = 4'b0001;
    req_data  = 32'h0000_00D7;
    push(2'd0, 8'hD7);
    step();
    check("ds_start", {tx_start, tx_baud, req_ready}, {2'b10, 4'b0001});
    req_valid = '0;
    done_pulse();
    check("ds_still_start", {busy, tx_start}, 2'b11);
    wait_baud("ds_baud");
    step();
    check("ds_busy", {busy, tx_start}, 2'b10);
    done_pulse();
    check("ds_idle", busy, 0);

    // Reset during BUSY: async clear, pending request re-arbitrated from pointer 0
    req_valid = 4'b0100;
    req_data  = 32'h00A5_0000;
    push(2'd2, 8'hA5);
    wait_ready("mr_ready");
    req_valid = 4'b1100;
    req_data  = 32'h4433_0000;
    wait_busy("mr_busy");
    #2;
    reset = 1'b1;
    #1;
    check("mr_async", {tx_start, busy, req_ready, grant_id, data_out}, 32'h0);
    push(2'd2, 8'h33);
    #2;
    reset = 1'b0;
    wait_ready("mr_ready2");
    req_valid = '0;
    check("mr_regrant", {grant_id, data_out}, {2'd2, 8'h33});
    wait_busy("mr_busy2");
    done_pulse();

    step();
    check("sb_empty", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
